// File: rtl/adbg_or1k_biu_ext.sv
`default_nettype none
// ---- adbg_or1k_biu_ext: TCK-to-OR1K SPR bridge with toggle CDC, auto-increment, ack timeout -- rev 1.0 ----
module adbg_or1k_biu_ext #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int ADDR_STEP = 1,
  parameter int TIMEOUT   = 255
) (
  input  logic              cpu_clk_i,
  input  logic              rst_i,
  input  logic              tck_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              inc_i,
  input  logic              rd_wrn_i,
  input  logic              strobe_i,
  input  logic              err_clr_i,
  output logic              rdy_o,
  output logic [DATA_W-1:0] data_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] cpu_addr_o,
  output logic [DATA_W-1:0] cpu_data_o,
  output logic              cpu_we_o,
  output logic              cpu_stb_o,
  input  logic [DATA_W-1:0] cpu_data_i,
  input  logic              cpu_ack_i
);

  localparam int          TCNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int          TLIM    = (TIMEOUT >= 2) ? (TIMEOUT - 2) : 0;
  localparam logic        TO_EN   = (TIMEOUT != 0);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } state_t;

  // TCK-domain state
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_in_q;
  logic              wr_q;
  logic              str_sync_q;
  logic              rdy_q;
  logic              err_q;
  logic              err_d;
  logic [2:0]        rdy_sync_q;
  logic              accept;
  logic              rdy_toggle;

  // CPU-domain state
  state_t            state_q;
  logic [2:0]        str_s_q;
  logic [TCNT_W-1:0] tcnt_q;
  logic [DATA_W-1:0] data_out_q;
  logic              cpu_err_q;
  logic              rdy_tgl_q;
  logic              start_toggle;
  logic              done;
  logic              abort;

  assign accept     = strobe_i & rdy_q;
  assign rdy_toggle = rdy_sync_q[1] ^ rdy_sync_q[2];
  assign addr_d     = inc_i ? (addr_q + ADDR_W'(ADDR_STEP)) : addr_i;
  // A timeout set on the same edge as a clear takes precedence.
  assign err_d      = (err_q & ~err_clr_i) | (rdy_toggle & cpu_err_q);

  always_ff @(posedge tck_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q     <= '0;
      data_in_q  <= '0;
      wr_q       <= 1'b0;
      str_sync_q <= 1'b0;
      rdy_q      <= 1'b1;
      err_q      <= 1'b0;
      rdy_sync_q <= 3'b000;
    end else begin
      rdy_sync_q <= {rdy_sync_q[1:0], rdy_tgl_q};
      err_q      <= err_d;
      if (accept) begin
        addr_q     <= addr_d;
        wr_q       <= ~rd_wrn_i;
        str_sync_q <= ~str_sync_q;
        rdy_q      <= 1'b0;
        if (!rd_wrn_i) begin
          data_in_q <= data_i;
        end
      end else if (rdy_toggle) begin
        rdy_q <= 1'b1;
      end
    end
  end

  assign start_toggle = str_s_q[1] ^ str_s_q[2];
  assign cpu_stb_o    = (state_q == S_XFER) | ((state_q == S_IDLE) & start_toggle);
  assign done         = cpu_stb_o & cpu_ack_i;
  // An ack in the last allowed cycle wins over the abort.
  assign abort        = TO_EN & (state_q == S_XFER) & ~cpu_ack_i &
                        (tcnt_q == TCNT_W'(TLIM));

  always_ff @(posedge cpu_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      str_s_q    <= 3'b000;
      tcnt_q     <= '0;
      data_out_q <= '0;
      cpu_err_q  <= 1'b0;
      rdy_tgl_q  <= 1'b0;
    end else begin
      str_s_q <= {str_s_q[1:0], str_sync_q};
      case (state_q)
        S_IDLE: begin
          if (start_toggle && !cpu_ack_i) begin
            state_q <= S_XFER;
            tcnt_q  <= '0;
          end
        end
        S_XFER: begin
          tcnt_q <= tcnt_q + 1'b1;
          if (cpu_ack_i || abort) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      if (done) begin
        if (!wr_q) begin
          data_out_q <= cpu_data_i;
        end
        cpu_err_q <= 1'b0;
        rdy_tgl_q <= ~rdy_tgl_q;
      end else if (abort) begin
        if (!wr_q) begin
          data_out_q <= '0;
        end
        cpu_err_q <= 1'b1;
        rdy_tgl_q <= ~rdy_tgl_q;
      end
    end
  end

  assign rdy_o      = rdy_q;
  assign err_o      = err_q;
  assign data_o     = data_out_q;
  assign cpu_addr_o = addr_q;
  assign cpu_data_o = data_in_q;
  assign cpu_we_o   = wr_q;

endmodule
`default_nettype wire

// File: tb/tb_adbg_or1k_biu_ext.sv
`default_nettype none
`timescale 1ns/1ps
// ---- tb_adbg_or1k_biu_ext: scoreboard bench for the debug-to-SPR bridge -- rev 1.0 ----
module tb_adbg_or1k_biu_ext;

  localparam int TO = 8;

  logic        cpu_clk = 1'b0;
  logic        tck     = 1'b0;
  logic        rst_i   = 1'b1;
  logic [31:0] data_i  = '0;
  logic [31:0] addr_i  = '0;
  logic        inc_i   = 1'b0;
  logic        rd_wrn_i = 1'b0;
  logic        strobe_i = 1'b0;
  logic        err_clr_i = 1'b0;
  logic        rdy_o;
  logic [31:0] data_o;
  logic        err_o;
  logic [31:0] cpu_addr_o;
  logic [31:0] cpu_data_o;
  logic        cpu_we_o;
  logic        cpu_stb_o;
  logic [31:0] cpu_data_i = '0;
  logic        cpu_ack_i  = 1'b0;

  int cpu_half = 10;
  always #50 tck = ~tck;
  always #cpu_half cpu_clk = ~cpu_clk;

  adbg_or1k_biu_ext #(
    .DATA_W(32), .ADDR_W(32), .ADDR_STEP(1), .TIMEOUT(TO)
  ) dut (
    .cpu_clk_i(cpu_clk), .rst_i(rst_i), .tck_i(tck),
    .data_i(data_i), .addr_i(addr_i), .inc_i(inc_i), .rd_wrn_i(rd_wrn_i),
    .strobe_i(strobe_i), .err_clr_i(err_clr_i),
    .rdy_o(rdy_o), .data_o(data_o), .err_o(err_o),
    .cpu_addr_o(cpu_addr_o), .cpu_data_o(cpu_data_o), .cpu_we_o(cpu_we_o),
    .cpu_stb_o(cpu_stb_o), .cpu_data_i(cpu_data_i), .cpu_ack_i(cpu_ack_i)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
    int          len;
  } txn_t;

  txn_t sb[$];
  txn_t cur;
  int   checks = 0;
  int   failures = 0;
  int   stb_cnt = 0;
  int   ack_delay = 0;

  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_rdata = '0;
  logic        m_err = 1'b0;
  bit          cur_rd;
  bit          cur_to;
  logic [31:0] cur_rdata;

  // SPR responder and scoreboard consumer, evaluated mid-cycle
  always @(negedge cpu_clk) begin
    if (rst_i) begin
      stb_cnt   = 0;
      cpu_ack_i = 1'b0;
    end else if (cpu_stb_o) begin
      stb_cnt = stb_cnt + 1;
      if (stb_cnt == 1) begin
        checks = checks + 1;
        if (sb.size() == 0) begin
          failures = failures + 1;
          $display("FAIL unexpected_stb: stb seen with no access pending, addr=%h", cpu_addr_o);
          cur = '{32'h0, 1'b0, 32'h0, -1};
        end else begin
          cur = sb.pop_front();
          if (cpu_addr_o !== cur.addr || cpu_we_o !== cur.we || cpu_data_o !== cur.data) begin
            failures = failures + 1;
            $display("FAIL spr_bus: got addr=%h we=%b data=%h, want addr=%h we=%b data=%h",
                     cpu_addr_o, cpu_we_o, cpu_data_o, cur.addr, cur.we, cur.data);
          end
        end
      end
      cpu_ack_i = (ack_delay != 0) && (stb_cnt == ack_delay);
    end else begin
      if (stb_cnt != 0 && cur.len >= 0) begin
        checks = checks + 1;
        if (stb_cnt != cur.len) begin
          failures = failures + 1;
          $display("FAIL stb_len: got %0d cycles, want %0d", stb_cnt, cur.len);
        end
      end
      stb_cnt   = 0;
      cpu_ack_i = 1'b0;
    end
  end

  task automatic reset_models();
    m_addr = '0; m_wdata = '0; m_rdata = '0; m_err = 1'b0;
    sb.delete();
  endtask

  task automatic start_access(input logic [31:0] addr, input bit inc, input bit rd,
                              input logic [31:0] wdata, input int delay,
                              input logic [31:0] rdata, input bit skip_len);
    int len;
    cur_to    = (delay == 0) || (delay > TO);
    len       = skip_len ? -1 : (cur_to ? TO : delay);
    cur_rd    = rd;
    cur_rdata = rdata;
    m_addr    = inc ? m_addr + 32'd1 : addr;
    if (!rd) m_wdata = wdata;
    sb.push_back('{m_addr, ~rd, m_wdata, len});
    ack_delay  = delay;
    cpu_data_i = rdata;
    @(negedge tck);
    addr_i = addr; inc_i = inc; rd_wrn_i = rd; data_i = wdata; strobe_i = 1'b1;
    @(negedge tck);
    strobe_i = 1'b0;
    checks = checks + 1;
    if (rdy_o !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL accept_rdy: rdy_o=%b after strobe, want 0", rdy_o);
    end
  endtask

  task automatic finish_access();
    int n = 0;
    while (rdy_o !== 1'b1 && n < 300) begin
      @(negedge tck);
      n++;
    end
    checks = checks + 1;
    if (rdy_o !== 1'b1) begin
      failures = failures + 1;
      $display("FAIL rdy_return: rdy_o=%b after %0d tck cycles, want 1", rdy_o, n);
    end
    if (cur_rd) m_rdata = cur_to ? 32'h0 : cur_rdata;
    m_err = m_err | cur_to;
    checks = checks + 1;
    if (data_o !== m_rdata || err_o !== m_err) begin
      failures = failures + 1;
      $display("FAIL completion: data_o=%h err_o=%b, want data_o=%h err_o=%b",
               data_o, err_o, m_rdata, m_err);
    end
  endtask

  task automatic test_reset();
    @(negedge tck);
    rst_i = 1'b1;
    #1;
    checks = checks + 1;
    if (rdy_o !== 1'b1 || err_o !== 1'b0 || data_o !== 32'h0 || cpu_stb_o !== 1'b0 ||
        cpu_we_o !== 1'b0 || cpu_addr_o !== 32'h0 || cpu_data_o !== 32'h0) begin
      failures = failures + 1;
      $display("FAIL reset_vals: rdy=%b err=%b data=%h stb=%b we=%b addr=%h wdata=%h, want 1 0 0 0 0 0 0",
               rdy_o, err_o, data_o, cpu_stb_o, cpu_we_o, cpu_addr_o, cpu_data_o);
    end
    repeat (3) @(negedge tck);
    rst_i = 1'b0;
    reset_models();
  endtask

  task automatic test_single_write();
    start_access(32'h2800, 1'b0, 1'b0, 32'hDEADBEEF, 1, 32'h0, 1'b0);
    finish_access();
    checks = checks + 1;
    if (err_o !== 1'b0 || cpu_addr_o !== 32'h2800) begin
      failures = failures + 1;
      $display("FAIL single_write: err=%b addr=%h, want err=0 addr=00002800", err_o, cpu_addr_o);
    end
  endtask

  task automatic test_multi_read();
    start_access(32'h0033, 1'b0, 1'b1, 32'h0, 5, 32'h12345678, 1'b0);
    finish_access();
    checks = checks + 1;
    if (data_o !== 32'h12345678) begin
      failures = failures + 1;
      $display("FAIL multi_read: data_o=%h, want 12345678", data_o);
    end
  endtask

  task automatic test_auto_inc();
    logic [31:0] want;
    start_access(32'h100, 1'b0, 1'b0, 32'h11110000, 1, 32'h0, 1'b0);
    finish_access();
    for (int i = 1; i <= 3; i++) begin
      start_access(32'hAAAA_0000, 1'b1, 1'b0, 32'h11110000 + i, 2, 32'h0, 1'b0);
      finish_access();
      want = 32'h100 + i;
      checks = checks + 1;
      if (cpu_addr_o !== want) begin
        failures = failures + 1;
        $display("FAIL auto_inc: addr=%h, want %h", cpu_addr_o, want);
      end
    end
    start_access(32'hFFFFFFFF, 1'b0, 1'b0, 32'h5, 1, 32'h0, 1'b0);
    finish_access();
    start_access(32'h1234, 1'b1, 1'b1, 32'h0, 3, 32'hCAFEF00D, 1'b0);
    finish_access();
    checks = checks + 1;
    if (cpu_addr_o !== 32'h0) begin
      failures = failures + 1;
      $display("FAIL addr_wrap: addr=%h, want 00000000", cpu_addr_o);
    end
  endtask

  task automatic test_ignored_strobe();
    start_access(32'h0040, 1'b0, 1'b0, 32'h0BADF00D, 6, 32'h0, 1'b0);
    @(negedge tck);
    addr_i = 32'h7777; data_i = 32'h99999999; rd_wrn_i = 1'b1; strobe_i = 1'b1;
    @(negedge tck);
    strobe_i = 1'b0;
    checks = checks + 1;
    if (cpu_addr_o !== 32'h0040 || cpu_data_o !== 32'h0BADF00D || cpu_we_o !== 1'b1) begin
      failures = failures + 1;
      $display("FAIL ignored_strobe: addr=%h data=%h we=%b, want 00000040 0badf00d 1",
               cpu_addr_o, cpu_data_o, cpu_we_o);
    end
    finish_access();
  endtask

  task automatic test_timeout();
    start_access(32'h0050, 1'b0, 1'b1, 32'h0, 0, 32'hFFFF0000, 1'b0);
    finish_access();
    checks = checks + 1;
    if (err_o !== 1'b1 || data_o !== 32'h0) begin
      failures = failures + 1;
      $display("FAIL timeout: err=%b data=%h, want err=1 data=0", err_o, data_o);
    end
    start_access(32'h0051, 1'b0, 1'b0, 32'h600D, 2, 32'h0, 1'b0);
    finish_access();
    checks = checks + 1;
    if (err_o !== 1'b1) begin
      failures = failures + 1;
      $display("FAIL err_sticky: err=%b, want 1", err_o);
    end
    @(negedge tck); err_clr_i = 1'b1;
    @(negedge tck); err_clr_i = 1'b0;
    m_err = 1'b0;
    checks = checks + 1;
    if (err_o !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL err_clear: err=%b, want 0", err_o);
    end
  endtask

  task automatic test_timeout_boundary();
    start_access(32'h0060, 1'b0, 1'b1, 32'h0, TO, 32'hA5A55A5A, 1'b0);
    finish_access();
    checks = checks + 1;
    if (err_o !== 1'b0 || data_o !== 32'hA5A55A5A) begin
      failures = failures + 1;
      $display("FAIL to_boundary: err=%b data=%h, want err=0 data=a5a55a5a", err_o, data_o);
    end
  endtask

  task automatic test_reset_in_xfer();
    int n = 0;
    start_access(32'h0070, 1'b0, 1'b0, 32'h77, 0, 32'h0, 1'b1);
    while (stb_cnt < 3 && n < 100) begin
      @(negedge cpu_clk);
      n++;
    end
    checks = checks + 1;
    if (stb_cnt < 3) begin
      failures = failures + 1;
      $display("FAIL xfer_reach: stb_cnt=%0d, want >=3", stb_cnt);
    end
    #3 rst_i = 1'b1;
    #1;
    checks = checks + 1;
    if (cpu_stb_o !== 1'b0 || rdy_o !== 1'b1 || err_o !== 1'b0 || data_o !== 32'h0 ||
        cpu_addr_o !== 32'h0 || cpu_data_o !== 32'h0 || cpu_we_o !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL reset_xfer: stb=%b rdy=%b err=%b data=%h addr=%h wdata=%h we=%b, want 0 1 0 0 0 0 0",
               cpu_stb_o, rdy_o, err_o, data_o, cpu_addr_o, cpu_data_o, cpu_we_o);
    end
    repeat (3) @(negedge tck);
    rst_i = 1'b0;
    reset_models();
  endtask

  task automatic run_suite();
    test_reset();
    test_single_write();
    test_multi_read();
    test_auto_inc();
    test_ignored_strobe();
    test_timeout();
    test_timeout_boundary();
    test_back_to_back();
    test_reset_in_xfer();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      start_access(32'h0200 + i, 1'b0, i[0], 32'hB0B0_0000 + i, 1 + i, 32'hC0DE_0000 + i, 1'b0);
      finish_access();
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge tck);
    rst_i = 1'b0;
    cpu_half = 10;
    run_suite();
    cpu_half = 71;
    repeat (4) @(negedge tck);
    run_suite();
    repeat (4) @(negedge tck);
    checks = checks + 1;
    if (sb.size() != 0) begin
      failures = failures + 1;
      $display("FAIL sb_drain: %0d accesses never seen on the SPR bus", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adbg_or1k_biu_ext.md
# adbg_or1k_biu_ext

Parametrised debug-to-OR1K SPR bus bridge for the advanced debug unit's CPU module. It accepts single accesses in the TCK domain and replays them on the CPU SPR bus in the cpu_clk_i domain, using toggle synchronisers in both directions. Beyond a plain bridge, it adds configurable data and address widths, address auto-increment for block transfers, and a per-access ack timeout with a sticky error flag, so a hung CPU cannot wedge the debug chain.

## Interface
- DATA_W, 32, data width of the debug and SPR data paths.
- ADDR_W, 32, SPR address width.
- ADDR_STEP, 1, increment applied to the address when inc_i is set.
- TIMEOUT, 255, number of cpu_clk_i cycles cpu_stb_o may stay high without cpu_ack_i. 0 disables the timeout; otherwise it must be ≥2.

Ports:
- cpu_clk_i  in  1  CPU clock.
- rst_i  in  1  reset, asynchronous, active-high; clock cpu_clk_i. The same rst_i also asynchronously resets all tck_i-domain flops.
- tck_i  in  1  debug (TCK) clock.
- data_i  in  DATA_W  write data. Short words are in the upper bits.
- addr_i  in  ADDR_W  access address, used when inc_i=0.
- inc_i  in  1  when set, the access uses the previous address + ADDR_STEP instead of addr_i.
- rd_wrn_i  in  1  1 = read, 0 = write.
- strobe_i  in  1  access request, sampled on tck_i.
- err_clr_i  in  1  clears err_o.
- rdy_o  out  1  bridge idle; a strobe is accepted only when rdy_o=1.
- data_o  out  DATA_W  read data from the last completed read.
- err_o  out  1  sticky flag: an access has timed out.
- cpu_addr_o  out  ADDR_W  SPR address.
- cpu_data_o  out  DATA_W  SPR write data.
- cpu_we_o  out  1  SPR write enable.
- cpu_stb_o  out  1  SPR strobe.
- cpu_data_i  in  DATA_W  SPR read data.
- cpu_ack_i  in  1  SPR acknowledge.

## Operation
**Reset values:**
- rdy_o=1; err_o=0; data_o=0.
- cpu_stb_o=0, cpu_we_o=0, cpu_addr_o=0, cpu_data_o=0.
- Both FSMs return to IDLE, and every synchroniser and toggle flop is 0.

**TCK domain:**
- A strobe is accepted on a tck_i edge where strobe_i=1 and rdy_o=1. On acceptance:
  - addr_reg is loaded with inc_i ? addr_reg+ADDR_STEP : addr_i.
  - data_in_reg is loaded from data_i on writes only.
  - wr_reg is set to ~rd_wrn_i.
  - str_sync toggles.
  - rdy_o falls on the same edge.
- Address increment wraps modulo 2^ADDR_W.
- A strobe while rdy_o=0 is ignored, with no side effects.
- rdy_sync passes through a 2-flop synchroniser plus an edge-detect flop. A detected toggle:
  - sets rdy_o=1;
  - samples cpu_err_reg and ORs it into err_o.
- err_clr_i=1 clears err_o. If a set and a clear land on the same edge, the set wins.

**CPU domain:**
- str_sync passes through a 2-flop synchroniser; a change in the synchronised value is start_toggle.
- FSM states are IDLE and XFER.
- In IDLE with start_toggle:
  - cpu_stb_o=1 (combinational).
  - If cpu_ack_i is also high, the access completes in that cycle and the FSM stays in IDLE.
  - Otherwise the FSM goes to XFER and the timeout counter tcnt is cleared to 0.
- In XFER, cpu_stb_o=1 and tcnt increments every cycle. Each cycle resolves as follows:
  - cpu_ack_i=1: the access completes and the FSM returns to IDLE.
  - TIMEOUT≠0, tcnt==TIMEOUT-2 and no ack: the access aborts and the FSM returns to IDLE. At that point cpu_stb_o has been high for exactly TIMEOUT cycles.
- Completion does the following:
  - On reads, data_out_reg latches cpu_data_i.
  - cpu_err_reg is cleared to 0.
  - rdy_sync toggles.
- An abort does the following:
  - On reads, data_out_reg is loaded with 0.
  - cpu_err_reg is set to 1.
  - rdy_sync toggles.
- An ack in the final allowed cycle counts as completion, not abort.
- cpu_addr_o, cpu_data_o and cpu_we_o are driven directly from the TCK registers. They are quasi-static: they only change while rdy_o=1.
- data_o and cpu_err_reg are quasi-static toward the TCK domain: they are stable for at least two tck_i edges before the rdy toggle is detected.

## Timing
- The first cpu_stb_o cycle occurs 2–3 cpu_clk_i edges after the accepting tck_i edge.
- A single-cycle ack gives a stb pulse of exactly 1 cycle.
- rdy_o rises 3–4 tck_i edges after the completing cpu_clk_i edge.
- Reset asserted mid-operation aborts the access immediately:
  - cpu_stb_o drops asynchronously;
  - neither err_o nor data_o is updated.
- At most one access is outstanding at any time.

## Test plan
- **Single-cycle write:** TCK strobe with addr=0x2800, data=0xDEADBEEF, rd_wrn=0; cpu_ack_i is high on the first stb cycle → one stb cycle with we=1, addr=0x2800, data=0xDEADBEEF; rdy_o returns to 1; err_o=0.
- **Multi-cycle read:** ack after 5 stb cycles with cpu_data_i=0x12345678 → stb high for exactly 5 cycles; data_o=0x12345678; rdy_o=1.
- **Auto-increment:** write to 0x100, then three strobes with inc_i=1 (ADDR_STEP=1) → cpu_addr_o is 0x101, 0x102, 0x103. With addr=0xFFFFFFFF followed by inc_i=1 → the address wraps to 0x0.
- **Timeout (TIMEOUT=8), ack never asserted:**
  - stb is high for exactly 8 cycles, then drops;
  - rdy_o returns to 1 with err_o=1 and data_o=0;
  - the next good access leaves err_o=1;
  - err_clr_i then clears it.
- **Timeout boundary (TIMEOUT=8):** ack arrives in stb cycle 8 → the access completes normally with err_o=0.
- **Robustness:**
  - A strobe while rdy_o=0 is ignored and address/data are unchanged.
  - rst_i asserted during XFER → stb drops, rdy_o=1, and all outputs return to their reset values.
  - The bench runs with tck_i at 10 MHz against cpu_clk_i at 50 MHz and 7 MHz.
